// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings, BTB entry
// layout and the PC-to-index/tag split.
package bp_pkg;

    localparam int XLEN        = 32;
    localparam int IDX_BITS    = 4;
    localparam int TAG_BITS    = 8;
    localparam int NUM_ENTRIES = 1 << IDX_BITS;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        ctr_t                ctr;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    // Saturating two-bit counter step; ST and SNT hold rather than wrap.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return ctr_t'(nxt);
    endfunction

    function automatic logic [IDX_BITS-1:0] pc_index(input logic [XLEN-1:0] pc);
        return pc[IDX_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [XLEN-1:0] pc);
        return pc[IDX_BITS+2 +: TAG_BITS];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, resolved-branch update and mispredict signals of the predictor.
interface branch_predictor_if;
    import bp_pkg::*;

    logic [XLEN-1:0] if_pc;
    logic            prediction;
    logic [XLEN-1:0] control_pc;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_predicted;
    logic [XLEN-1:0] upd_pred_target;

    logic            flush;
    logic [XLEN-1:0] pc_branch;
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted, upd_pred_target,
        input  prediction, control_pc, flush, pc_branch, br_count, mispred_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted, upd_pred_target,
        output prediction, control_pc, flush, pc_branch, br_count, mispred_count
    );

endinterface

// File: rtl/bp_table.sv
// Direct-mapped BTB with 2-bit counters: one combinational lookup port and one
// read-modify-write update port; lookup always sees pre-update contents.
module bp_table
    import bp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_valid,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    bp_entry_t entries [NUM_ENTRIES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    bp_entry_t           rd_entry;
    bp_entry_t           wr_entry;
    logic                wr_hit;

    assign rd_idx   = pc_index(rd_pc);
    assign rd_entry = entries[rd_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == pc_tag(rd_pc));
    assign rd_taken = rd_entry.ctr[1];
    assign rd_target = rd_entry.target;

    assign wr_idx   = pc_index(wr_pc);
    assign wr_tag   = pc_tag(wr_pc);
    assign wr_entry = entries[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= ENTRY_RESET;
            end
        end else if (wr_valid) begin
            if (wr_hit) begin
                entries[wr_idx].ctr <= sat_update(wr_entry.ctr, wr_taken);
                if (wr_taken) entries[wr_idx].target <= wr_target;
            end else if (wr_taken) begin
                // Taken miss replaces whatever aliases to this index.
                entries[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: WT};
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: BTB lookup for IF, mispredict detection and
// correct-PC generation for resolved branches, plus branch/mispredict counters.
module branch_predictor
    import bp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);

    logic            rd_hit;
    logic            rd_taken;
    logic [XLEN-1:0] rd_target;
    logic            flush;

    bp_table u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (bus.if_pc),
        .rd_hit    (rd_hit),
        .rd_taken  (rd_taken),
        .rd_target (rd_target),
        .wr_valid  (bus.upd_valid),
        .wr_pc     (bus.upd_pc),
        .wr_taken  (bus.upd_taken),
        .wr_target (bus.upd_target)
    );

    assign bus.prediction = rd_hit & rd_taken;
    assign bus.control_pc = bus.prediction ? rd_target : bus.if_pc + 32'd4;

    // Wrong direction, or right direction but the carried target went stale.
    assign flush = bus.upd_valid &
                   ((bus.upd_taken != bus.upd_predicted) |
                    (bus.upd_taken & bus.upd_predicted & (bus.upd_pred_target != bus.upd_target)));
    assign bus.flush     = flush;
    assign bus.pc_branch = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.br_count      <= '0;
            bus.mispred_count <= '0;
        end else begin
            if (bus.upd_valid) bus.br_count      <= bus.br_count + 32'd1;
            if (flush)         bus.mispred_count <= bus.mispred_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed lookups, flushes and counts.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    branch_predictor_if bus ();

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
        bus.upd_valid       = v;
        bus.upd_pc          = pc;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_predicted   = pr;
        bus.upd_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic pred, input logic [31:0] cpc);
        bus.if_pc = pc;
        #1;
        check_val({tag, "_pred"}, {31'd0, bus.prediction}, {31'd0, pred});
        check_val({tag, "_cpc"}, bus.control_pc, cpc);
    endtask

    task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mis);
        check_val({tag, "_br"}, bus.br_count, br);
        check_val({tag, "_mis"}, bus.mispred_count, mis);
    endtask

    task automatic fl(input string tag, input logic f, input logic [31:0] pcb);
        check_val({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, f});
        if (f) check_val({tag, "_pcb"}, bus.pc_branch, pcb);
    endtask

    initial begin
        bus.if_pc = 32'h40;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        look("rst", 32'h40, 1'b0, 32'h44);
        fl("rst", 1'b0, 32'h0);
        counts("rst", 32'd0, 32'd0);

        // first taken branch: miss, mispredict, allocate with WT
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        fl("first", 1'b1, 32'h100);
        look("first_pre", 32'h40, 1'b0, 32'h44);
        tick();
        idle();
        look("first_post", 32'h40, 1'b1, 32'h100);
        counts("first", 32'd1, 32'd1);

        // hysteresis: three correct taken (WT->ST->ST->ST)
        for (int i = 0; i < 3; i++) begin
            set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            fl("hit_ok", 1'b0, 32'h0);
            tick();
        end
        idle();
        counts("hyst3", 32'd4, 32'd1);
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        fl("nt1", 1'b1, 32'h44);
        tick();
        idle();
        look("nt1", 32'h40, 1'b1, 32'h100);
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        look("nt2", 32'h40, 1'b0, 32'h44);
        counts("nt2", 32'd6, 32'd3);
        // drive down to SNT and hold there, then one taken must only reach WNT
        for (int i = 0; i < 2; i++) begin
            set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
            fl("nt_ok", 1'b0, 32'h0);
            tick();
        end
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        look("snt_up", 32'h40, 1'b0, 32'h44);
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        look("wnt_up", 32'h40, 1'b1, 32'h100);
        counts("wnt_up", 32'd10, 32'd5);

        // target change with correct direction
        set_upd(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        fl("tgt", 1'b1, 32'h200);
        tick();
        idle();
        look("tgt", 32'h40, 1'b1, 32'h200);
        look("lowbits", 32'h43, 1'b1, 32'h200);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        counts("tgt", 32'd11, 32'd6);

        // alias at same index, different tag
        set_upd(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        idle();
        look("alias40", 32'h40, 1'b0, 32'h44);
        look("alias80", 32'h80, 1'b1, 32'h300);
        set_upd(1'b1, 32'h1040, 1'b0, 32'h0, 1'b0, 32'h0);
        fl("miss_nt", 1'b0, 32'h0);
        tick();
        idle();
        look("miss_nt80", 32'h80, 1'b1, 32'h300);
        look("miss_nt1040", 32'h1040, 1'b0, 32'h1044);
        set_upd(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h300);
        fl("alias_nt", 1'b1, 32'h84);
        tick();
        idle();
        look("alias_nt", 32'h80, 1'b0, 32'h84);
        counts("alias", 32'd14, 32'd8);

        // same-index lookup during update sees old contents
        set_upd(1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 32'h0);
        tick();
        idle();
        look("sim_new", 32'h80, 1'b1, 32'h400);
        set_upd(1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 32'h400);
        look("sim_old", 32'h80, 1'b1, 32'h400);
        fl("sim", 1'b1, 32'h500);
        tick();
        idle();
        look("sim_after", 32'h80, 1'b1, 32'h500);

        // async reset between edges
        #1 rst = 1'b1;
        look("arst", 32'h80, 1'b0, 32'h84);
        counts("arst", 32'd0, 32'd0);
        fl("arst", 1'b0, 32'h0);
        #1 rst = 1'b0;
        tick();
        look("arst_post", 32'h80, 1'b0, 32'h84);
        counts("arst_post", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
